// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the segmented pipelined add/subtract unit.
//   OP_ADD / OP_SUB : operation encoding on in_op
//   flags_t         : per-result status flags (carry out, signed overflow, zero)
//   signed_ovf()    : two's-complement overflow from the operand and result sign bits
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  // Overflow happens only when both addends share a sign and the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_segment.sv
// addsub_segment: one SEG-bit ripple slice of the add/subtract carry chain plus its
// pipeline register. Slice IDX adds in_a/in_b bits [IDX*SEG +: SEG] with in_carry and
// writes the result into the matching slice of the running sum; all other operand and
// sum bits pass through unchanged so later slices and the flag logic can use them.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   pipeline advance; when low the register holds
//   in_valid, in_carry   beat valid and carry from the previous slice
//   in_a, in_b, in_sum   full-width operands (b already inverted for subtract) and partial sum
//   out_*                registered versions; out_carry is this slice's carry out
module addsub_segment #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_carry,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  output logic             out_valid,
  output logic             out_carry,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_sum
);

  localparam int LO = IDX * SEG;

  logic             valid_d, valid_q;
  logic             carry_d, carry_q;
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic [SEG:0]     slice_res;

  always_comb begin
    slice_res = {1'b0, in_a[LO +: SEG]} + {1'b0, in_b[LO +: SEG]} + {{SEG{1'b0}}, in_carry};
    valid_d   = valid_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    if (en) begin
      valid_d            = in_valid;
      carry_d            = slice_res[SEG];
      a_d                = in_a;
      b_d                = in_b;
      sum_d              = in_sum;
      sum_d[LO +: SEG]   = slice_res[SEG-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign out_valid = valid_q;
  assign out_carry = carry_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_sum   = sum_q;

endmodule

// File: rtl/seg_pipe_addsub.sv
// seg_pipe_addsub: pipelined WIDTH-bit add/subtract with the carry chain split into
// STAGES equal slices (latency STAGES cycles, one beat per cycle) and valid/ready flow
// control. WIDTH must be a multiple of STAGES.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              operand handshake
//   in_a, in_b, in_cin, in_op      operands, carry-in, op (0: A+B+cin, 1: A+~B+cin)
//   out_valid/out_ready            result handshake
//   out_sum, out_cout, out_of,     result, carry out of the MSB, signed overflow,
//   out_zero                       result-is-zero
// Build option: define SEG_PIPE_SAT_EN to saturate out_sum on signed overflow.
module seg_pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_of,
  output logic             out_zero
);

  localparam int SEG = WIDTH / STAGES;

  // Index 0 is the unregistered input beat; index k is the output of slice k-1.
  logic [STAGES:0]  st_valid;
  logic [STAGES:0]  st_carry;
  logic [WIDTH-1:0] st_a   [0:STAGES];
  logic [WIDTH-1:0] st_b   [0:STAGES];
  logic [WIDTH-1:0] st_sum [0:STAGES];

  logic             advance;
  logic             ovf_raw;
  logic [WIDTH-1:0] sum_final;
  flags_t           flags;

  // Whole pipeline moves as one shift register; any stall freezes every stage.
  assign advance   = !st_valid[STAGES] || out_ready;
  assign in_ready  = advance;

  assign st_valid[0] = in_valid;
  assign st_carry[0] = in_cin;
  assign st_a[0]     = in_a;
  assign st_b[0]     = (in_op == OP_SUB) ? ~in_b : in_b;
  assign st_sum[0]   = '0;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_seg
      addsub_segment #(
        .WIDTH (WIDTH),
        .SEG   (SEG),
        .IDX   (gi)
      ) u_seg (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (advance),
        .in_valid  (st_valid[gi]),
        .in_carry  (st_carry[gi]),
        .in_a      (st_a[gi]),
        .in_b      (st_b[gi]),
        .in_sum    (st_sum[gi]),
        .out_valid (st_valid[gi+1]),
        .out_carry (st_carry[gi+1]),
        .out_a     (st_a[gi+1]),
        .out_b     (st_b[gi+1]),
        .out_sum   (st_sum[gi+1])
      );
    end
  endgenerate

  // Flags are masked with valid so an empty output slot never advertises stale status.
  always_comb begin
    ovf_raw   = signed_ovf(st_a[STAGES][WIDTH-1], st_b[STAGES][WIDTH-1], st_sum[STAGES][WIDTH-1]);
    sum_final = st_sum[STAGES];
`ifdef SEG_PIPE_SAT_EN
    // Clamp toward the sign of A: overflow only occurs when A and b_eff share it.
    if (ovf_raw) begin
      sum_final = st_a[STAGES][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    sum_final = st_sum[STAGES];
`endif
    flags      = '0;
    flags.cout = st_valid[STAGES] & st_carry[STAGES];
    flags.ovf  = st_valid[STAGES] & ovf_raw;
    flags.zero = st_valid[STAGES] & (sum_final == '0);
  end

  assign out_valid = st_valid[STAGES];
  assign out_sum   = sum_final;
  assign out_cout  = flags.cout;
  assign out_of    = flags.ovf;
  assign out_zero  = flags.zero;

endmodule

// File: tb/tb_seg_pipe_addsub.sv
// Testbench for seg_pipe_addsub: directed vector table, reset-in-flight sequence,
// back-pressure stream and full-rate streams on STAGES = 4, 1 and 32 instances.
module tb_seg_pipe_addsub;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_cin = 1'b0, in_op = 1'b0;
  logic        in_ready, out_valid, out_cout, out_of, out_zero;
  logic [31:0] out_sum;

  // secondary full-rate instances
  logic        fr_en = 1'b0;
  logic        s_valid;
  logic        r1_ready, r1_valid, r1_cout, r1_of, r1_zero;
  logic [31:0] r1_sum;
  logic        r32_ready, r32_valid, r32_cout, r32_of, r32_zero;
  logic [31:0] r32_sum;
  assign s_valid = fr_en & in_valid & in_ready;

  seg_pipe_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_of(out_of), .out_zero(out_zero));

  seg_pipe_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(r1_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
    .out_valid(r1_valid), .out_ready(1'b1), .out_sum(r1_sum),
    .out_cout(r1_cout), .out_of(r1_of), .out_zero(r1_zero));

  seg_pipe_addsub #(.WIDTH(32), .STAGES(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(r32_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
    .out_valid(r32_valid), .out_ready(1'b1), .out_sum(r32_sum),
    .out_cout(r32_cout), .out_of(r32_of), .out_zero(r32_zero));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: one wide adder, flags derived from its result.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic op);
    logic [31:0] be;
    logic [32:0] r;
    logic [31:0] s;
    logic        ovf;
    be  = op ? ~b : b;
    r   = {1'b0, a} + {1'b0, be} + {32'b0, cin};
    s   = r[31:0];
    ovf = (a[31] == be[31]) && (s[31] != a[31]);
`ifdef SEG_PIPE_SAT_EN
    if (ovf) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {s, r[32], ovf, (s == 32'h0)};
  endfunction

  typedef struct {
    logic [34:0] r;
    int          c;
  } exp_t;
  exp_t q_main[$];
  exp_t q1[$];
  exp_t q32[$];

  logic        sb_en = 1'b0, lat_chk = 1'b0, acc_main = 1'b0, hold_prev = 1'b0;
  logic [35:0] held = '0;

  // Main-instance scoreboard: order, values, latency, and hold-while-stalled.
  always @(negedge clk) begin
    exp_t e;
    acc_main = in_valid && in_ready;
    if (sb_en) begin
      if (hold_prev) chk("stall_stable", {out_valid, out_sum, out_cout, out_of, out_zero}, held);
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (acc_main) q_main.push_back('{model(in_a, in_b, in_cin, in_op), cyc});
      if (out_valid && out_ready) begin
        if (q_main.size() == 0) chk("main_spurious", out_valid, 0);
        else begin
          e = q_main.pop_front();
          chk("main_res", {out_sum, out_cout, out_of, out_zero}, e.r);
          if (lat_chk) chk("main_lat", 64'(cyc - e.c), 4);
        end
      end
      hold_prev = out_valid && !out_ready;
      held      = {out_valid, out_sum, out_cout, out_of, out_zero};
    end else begin
      hold_prev = 1'b0;
    end
  end

  // STAGES=1 and STAGES=32 scoreboards, active during the full-rate run.
  always @(negedge clk) begin
    exp_t e;
    if (fr_en) begin
      if (s_valid) begin
        q1.push_back('{model(in_a, in_b, in_cin, in_op), cyc});
        q32.push_back('{model(in_a, in_b, in_cin, in_op), cyc});
      end
      if (r1_valid) begin
        if (q1.size() == 0) chk("s1_spurious", r1_valid, 0);
        else begin
          e = q1.pop_front();
          chk("s1_res", {r1_sum, r1_cout, r1_of, r1_zero}, e.r);
          chk("s1_lat", 64'(cyc - e.c), 1);
        end
      end
      if (r32_valid) begin
        if (q32.size() == 0) chk("s32_spurious", r32_valid, 0);
        else begin
          e = q32.pop_front();
          chk("s32_res", {r32_sum, r32_cout, r32_of, r32_zero}, e.r);
          chk("s32_lat", 64'(cyc - e.c), 32);
        end
      end
    end
  end

  task automatic new_beat();
    in_a   = $urandom;
    in_b   = $urandom;
    in_cin = 1'($urandom_range(0, 1));
    in_op  = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: in_a = 32'h7FFF_FFFF;
      1: in_a = 32'h8000_0000;
      2: in_b = in_a;
      default: ;
    endcase
  endtask

  // Streams n beats; out_ready is dropped for st_l cycles starting at loop cycle st_s.
  task automatic stream(input int n, input int st_s, input int st_l, input logic lc);
    int sent = 0;
    int k = 0;
    lat_chk = lc;
    sb_en   = 1'b1;
    @(posedge clk); #1;
    new_beat();
    in_valid = (n > 0);
    while ((sent < n || q_main.size() != 0 || q1.size() != 0 || q32.size() != 0) && k < n + 200) begin
      out_ready = !(k >= st_s && k < st_s + st_l);
      @(posedge clk); #1;
      k++;
      if (acc_main) begin
        sent++;
        if (sent < n) new_beat();
        else in_valid = 1'b0;
      end
    end
    chk("stream_sent", 64'(sent), 64'(n));
    chk("stream_drain", 64'(q_main.size() + q1.size() + q32.size()), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sb_en     = 1'b0;
    lat_chk   = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        cin, op;
    logic [31:0] sum;
    logic        cout, ovf, zero;
  } vec_t;
  vec_t vecs[10];

  task automatic run_vec(input int idx);
    int cnt;
    @(posedge clk); #1;
    in_a = vecs[idx].a; in_b = vecs[idx].b; in_cin = vecs[idx].cin; in_op = vecs[idx].op;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk($sformatf("v%0d_lat", idx), 64'(cnt), 4);
    chk($sformatf("v%0d_sum", idx), out_sum, vecs[idx].sum);
    chk($sformatf("v%0d_cout", idx), out_cout, vecs[idx].cout);
    chk($sformatf("v%0d_of", idx), out_of, vecs[idx].ovf);
    chk($sformatf("v%0d_zero", idx), out_zero, vecs[idx].zero);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, OP_ADD, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
`ifdef SEG_PIPE_SAT_EN
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, OP_SUB, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, OP_ADD, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, OP_ADD, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
`endif
    vecs[4] = '{32'h0000_0005, 32'h0000_0005, 1'b1, OP_SUB, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h0000_0003, 32'h0000_0005, 1'b1, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h1234_5678, 32'h0000_0000, 1'b0, OP_SUB, 32'h1234_5677, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, OP_ADD, 32'h0100_0101, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {out_valid, out_sum, out_cout, out_of, out_zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);

    // Directed table
    for (int i = 0; i < 10; i++) run_vec(i);

    // Reset with three beats in flight
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 32'h0000_0005; in_b = 32'h0000_0007; in_cin = 1'b0; in_op = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {out_valid, out_sum, out_cout, out_of, out_zero}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_hold", {out_valid, out_sum, out_cout, out_of, out_zero}, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_stale", 64'(seen), 0);
    chk("midrst_in_ready", in_ready, 1);

    // Back-pressure: 20 beats, 7-cycle out_ready drop mid-stream
    stream(20, 8, 7, 1'b0);

    // Full rate on all three configurations
    fr_en = 1'b1;
    stream(1000, 0, 0, 1'b1);
    fr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
